// File: rtl/fifo_read_stream_adapter.sv
// fifo_read_stream_adapter
// Read-side companion to a dual-clock FIFO with registered read data.
// It issues FIFO reads against a credit budget, captures the returned words
// into a small skid buffer, and presents the buffer head as a valid/ready
// stream that sustains one word per cycle under continuous demand.
//
// Stream handshake: a word transfers on a rising edge where m_valid and
// m_ready are both high. Once m_valid is high, m_valid and m_data stay
// unchanged until that transfer happens. m_ready may be high while m_valid
// is low; that has no effect.
module fifo_read_stream_adapter #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic              fifo_empty,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              idle
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int CRD_W = OCC_W + 1;

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              inflight_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop;
  logic [CRD_W-1:0]  credit_used;

  // Stream view: valid and head data come only from buffer registers, so
  // there is no combinational path from fifo_rdata to the stream outputs.
  assign m_valid    = (occ_q != '0);
  assign m_data     = mem_q[rd_ptr_q];
  assign xfer_count = cnt_q;
  assign pop        = m_valid & m_ready;
  assign idle       = (occ_q == '0) & ~inflight_q & fifo_empty;

  // Read issue: count buffered words plus the word already on its way, less
  // the one leaving this cycle. A read is only issued when the word it
  // returns is guaranteed a free slot, so capture never needs to stall.
  always_comb begin
    credit_used = CRD_W'(occ_q) + CRD_W'(inflight_q) - CRD_W'(pop);
    fifo_ren    = ~rrst & ~fifo_empty & (credit_used < CRD_W'(SKID_DEPTH));
  end

  // Next-state for pointers, occupancy and the wrapping transfer counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + OCC_W'(inflight_q) - OCC_W'(pop);
    cnt_d    = cnt_q;
    if (inflight_q) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Control registers; reset discards anything buffered or in flight.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_ren;
      cnt_q      <= cnt_d;
    end
  end

  // Skid storage: the word requested last cycle lands at the write pointer.
  // Entries are cleared on reset so the idle head reads as zero.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (inflight_q) begin
      mem_q[wr_ptr_q] <= fifo_rdata;
    end
  end

endmodule
